// File: rtl/axil_sig_reader.sv
// AXI-Lite read-master sequencer: walks a word-aligned byte range [begin, end)
// with one read outstanding and hands each returned word to a ready/valid sink.
module axil_sig_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_begin,
  input  logic [ADDR_WIDTH-1:0] cfg_end,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_OUT,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cfg_b;
  logic [ADDR_WIDTH-1:0]   cfg_e;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [ADDR_WIDTH-1:0]   end_addr;
  logic                    abort_pend;
  logic                    last_word;
  logic                    tmo;
  logic [TW-1:0]           tcnt;

  assign cfg_b    = cfg_begin & WORD_MASK;
  assign cfg_e    = cfg_end & WORD_MASK;
  assign addr_inc = addr + WORD_STEP;

  // The walk ends after this word on range end, a seen abort, or address wrap.
  assign last_word = (addr_inc >= end_addr) || abort_pend || abort || (addr_inc == '0);
  assign tmo       = (TIMEOUT != 0) && (tcnt == TMO_LAST);

  // All handshake outputs decode the registered state, so out_valid never
  // depends combinationally on out_ready.
  assign busy           = (state == S_ADDR) || (state == S_DATA) || (state == S_OUT);
  assign done           = (state == S_DONE);
  assign m_axil_arvalid = (state == S_ADDR);
  assign m_axil_rready  = (state == S_DATA);
  assign out_valid      = (state == S_OUT);
  assign m_axil_arprot  = '0;
  assign m_axil_araddr  = addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; AXI handshakes take priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_e <= cfg_b) state_nxt = S_DONE;
          else                state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axil_arready) state_nxt = S_DATA;
        else if (tmo)       state_nxt = S_DONE;
      end
      S_DATA: begin
        if (m_axil_rvalid) begin
          if (m_axil_rresp != 2'b00) state_nxt = S_DONE;
          else                       state_nxt = S_OUT;
        end else if (tmo) begin
          state_nxt = S_DONE;
        end
      end
      S_OUT: begin
        if (out_ready) state_nxt = last_word ? S_DONE : S_ADDR;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Walk datapath: address, bounds, captured word, counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      end_addr   <= '0;
      err        <= 1'b0;
      word_count <= '0;
      out_data   <= '0;
      out_addr   <= '0;
      abort_pend <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (busy && abort) abort_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (start) begin
            err        <= 1'b0;
            word_count <= '0;
            abort_pend <= 1'b0;
            end_addr   <= cfg_e;
            if (cfg_e > cfg_b) addr <= cfg_b;
          end
        end
        S_ADDR: begin
          if (m_axil_arready) begin
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tmo) err <= 1'b1;
          end
        end
        S_DATA: begin
          tcnt <= tcnt + 1'b1;
          if (m_axil_rvalid) begin
            out_data <= m_axil_rdata;
            out_addr <= addr;
            if (m_axil_rresp != 2'b00) err <= 1'b1;
          end else if (tmo) begin
            err <= 1'b1;
          end
        end
        S_OUT: begin
          tcnt <= '0;
          if (out_ready) begin
            word_count <= word_count + 1'b1;
            addr       <= addr_inc;
          end
        end
        default: tcnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sig_reader.sv
// Self-checking bench for axil_sig_reader: a table of walks, hand-written
// reset/timeout sequences and randomized walks against a range-walk model.
module tb_axil_sig_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] cfg_begin, cfg_end;
  logic        busy, done, err;
  logic [31:0] word_count, araddr, rdata, out_data, out_addr;
  logic [2:0]  arprot;
  logic        arvalid, arready, rvalid, rready, out_valid, out_ready;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  axil_sig_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_begin(cfg_begin), .cfg_end(cfg_end),
    .busy(busy), .done(done), .err(err), .word_count(word_count),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready)
  );

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  int tests = 0;
  int fails = 0;

  // Slave / sink configuration, written only by the main sequence.
  logic [31:0] bad_addr = NONE;
  bit          dead = 1'b0;
  bit          ready_mode = 1'b0;
  int          ar_delay = 0;
  int          r_delay = 0;

  // Observations, each written only by its own process.
  int          sst = 0;
  int          ar_count = 0;
  int          ar_stab = 0;
  int          out_stab = 0;
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return a ^ 32'hC3C3_0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: words in [b&~3, e&~3) step 4, stopping at a bad response, after
  // the aborted word, or on address wrap.
  task automatic model(input logic [31:0] b0, e0, bad, input int ab_at,
                       output int n, output bit er);
    logic [31:0] b, e, a;
    b = b0 & ~32'h3;
    e = e0 & ~32'h3;
    exp_a.delete();
    exp_d.delete();
    n = 0;
    er = 1'b0;
    a = b;
    while (e > b) begin
      if (a == bad) begin er = 1'b1; break; end
      exp_a.push_back(a);
      exp_d.push_back(mem_word(a));
      n++;
      if (ab_at >= 0 && n == ab_at + 1) break;
      a = a + 32'd4;
      if (a >= e || a == 32'd0) break;
    end
  endtask

  // AXI-Lite slave with configurable arready/rvalid latency.
  initial begin
    logic [31:0] lat;
    int wait_n;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; lat = '0; wait_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; rresp = '0; sst = 0;
      end else begin
        case (sst)
          0: if (arvalid && !dead) begin
               lat = araddr;
               if (ar_delay == 0) begin arready = 1'b1; sst = 2; end
               else begin wait_n = ar_delay - 1; sst = 1; end
             end
          1: begin
               if (!arvalid || araddr != lat) ar_stab++;
               if (wait_n == 0) begin arready = 1'b1; sst = 2; end
               else wait_n--;
             end
          2: begin
               arready = 1'b0;
               ar_count++;
               if (r_delay == 0) begin
                 rvalid = 1'b1; rdata = mem_word(lat);
                 rresp = (lat == bad_addr) ? 2'b10 : 2'b00; sst = 4;
               end else begin wait_n = r_delay - 1; sst = 3; end
             end
          3: if (wait_n == 0) begin
               rvalid = 1'b1; rdata = mem_word(lat);
               rresp = (lat == bad_addr) ? 2'b10 : 2'b00; sst = 4;
             end else wait_n--;
          default: begin rvalid = 1'b0; rresp = '0; sst = 0; end
        endcase
      end
    end
  end

  // Output sink: drives out_ready, records handoffs, checks stall stability.
  initial begin
    bit prev_stall;
    logic [31:0] pd, pa;
    prev_stall = 1'b0; pd = '0; pa = '0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0; out_ready = 1'b0;
      end else begin
        if (prev_stall && (!out_valid || out_data != pd || out_addr != pa)) out_stab++;
        out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          got_a.push_back(out_addr);
          got_d.push_back(out_data);
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data;
        pa = out_addr;
      end
    end
  end

  task automatic run_walk(input logic [31:0] b, e, bad, input bit rmode,
                          input int ard, rd, ab_at, exp_n, input bit exp_err);
    int n_m, cyc, base, ar0, ast0, ost0;
    bit er_m, aborted;
    model(b, e, bad, ab_at, n_m, er_m);
    bad_addr = bad; ready_mode = rmode; ar_delay = ard; r_delay = rd;
    @(negedge clk);
    base = got_a.size(); ar0 = ar_count; ast0 = ar_stab; ost0 = out_stab;
    cfg_begin = b; cfg_end = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared_by_start", err, 0);
    if ((e & ~32'h3) > (b & ~32'h3)) check("first_arvalid", {busy, arvalid, araddr}, {2'b11, b & ~32'h3});
    cyc = 0; aborted = 1'b0;
    while (!done && cyc < 3000) begin
      if (ab_at >= 0 && !aborted && sst == 1 && (ar_count - ar0) == ab_at) begin
        abort = 1'b1; aborted = 1'b1;
      end else abort = 1'b0;
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    check("done_seen", done, 1);
    if ((e & ~32'h3) <= (b & ~32'h3)) check("zero_len_latency", cyc, 0);
    check("word_count", word_count, exp_n);
    check("err", err, exp_err);
    check("ar_handshakes", ar_count - ar0, exp_n + int'(exp_err));
    check("words_emitted", got_a.size() - base, n_m);
    for (int i = 0; i < n_m && base + i < got_a.size(); i++) begin
      check("out_addr", got_a[base + i], exp_a[i]);
      check("out_data", got_d[base + i], exp_d[i]);
    end
    check("stall_stability", (ar_stab - ast0) + (out_stab - ost0), 0);
    @(negedge clk);
    check("done_one_cycle", {done, busy}, 2'b00);
  endtask

  typedef struct {
    logic [31:0] b, e, bad;
    bit          rmode;
    int          ard, rd, ab_at, exp_n;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cyc, n_r;
    bit er_r;
    logic [31:0] rb, re, rbad;

    tbl[0] = '{32'h100, 32'h110, NONE, 1'b0, 0, 0, -1, 4, 1'b0};
    tbl[1] = '{32'h200, 32'h200, NONE, 1'b0, 0, 0, -1, 0, 1'b0};
    tbl[2] = '{32'h210, 32'h200, NONE, 1'b0, 0, 0, -1, 0, 1'b0};
    tbl[3] = '{32'h300, 32'h314, NONE, 1'b1, 5, 7, -1, 5, 1'b0};
    tbl[4] = '{32'h400, 32'h410, 32'h404, 1'b0, 0, 0, -1, 1, 1'b1};
    tbl[5] = '{32'h503, 32'h50B, NONE, 1'b1, 1, 2, -1, 2, 1'b0};
    tbl[6] = '{32'h600, 32'h620, NONE, 1'b0, 4, 1, 2, 3, 1'b0};
    tbl[7] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, NONE, 1'b1, 1, 1, -1, 1, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_begin = '0; cfg_end = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {busy, done, err, arvalid, rready, out_valid}, 6'b0);
    check("reset_outs", {word_count, araddr}, 64'h0);
    check("reset_out_word", {out_data, out_addr}, 64'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_walk(tbl[i].b, tbl[i].e, tbl[i].bad, tbl[i].rmode, tbl[i].ard,
               tbl[i].rd, tbl[i].ab_at, tbl[i].exp_n, tbl[i].exp_err);
      if (tbl[i].exp_err) begin
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
      end
    end

    // Reset while waiting in S_DATA, then a fresh walk.
    bad_addr = NONE; ready_mode = 1'b0; ar_delay = 0; r_delay = 9;
    @(negedge clk);
    cfg_begin = 32'h700; cfg_end = 32'h710; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!rready && cyc < 50) begin @(negedge clk); cyc++; end
    check("reached_s_data", rready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midwalk_rst_flags", {busy, done, err, arvalid, rready, out_valid}, 6'b0);
    check("midwalk_rst_outs", {word_count, araddr}, 64'h0);
    check("midwalk_rst_out_word", {out_data, out_addr}, 64'h0);
    rst = 1'b0;
    run_walk(32'h700, 32'h710, NONE, 1'b1, 2, 3, -1, 4, 1'b0);

    // Dead slave: arready never comes, timeout flags err.
    dead = 1'b1;
    @(negedge clk);
    cfg_begin = 32'h800; cfg_end = 32'h810; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    check("timeout_done", done, 1);
    check("timeout_err", err, 1);
    check("timeout_latency_window", (cyc >= 15 && cyc <= 18), 1);
    check("timeout_word_count", word_count, 0);
    dead = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized walks against the model.
    for (int k = 0; k < 24; k++) begin
      rb = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) re = rb - $urandom_range(0, 8);
      else re = (rb & ~32'h3) + ($urandom_range(0, 6) << 2) + $urandom_range(0, 3);
      rbad = ($urandom_range(0, 2) == 0) ? (rb & ~32'h3) + ($urandom_range(0, 5) << 2) : NONE;
      model(rb, re, rbad, -1, n_r, er_r);
      run_walk(rb, re, rbad, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
               $urandom_range(0, 4), -1, n_r, er_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
